// File: rtl/serial_pkg.sv
// serial_pkg: shared frame states and default frame geometry for the serial frame sequencer.
package serial_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, HOLD, WAIT_IDLE} frame_state_t;
  localparam int WIDTH_DEF = 10;
  localparam int DIV_DEF = 4;
endpackage

// File: rtl/bit_timer.sv
// bit_timer: DIV-cycle bit-period counter with clear, mid-bit and end-of-bit strobes.
module bit_timer #(
  parameter int DIV = 4
) (
  input  logic CLK,
  input  logic RSTn,
  input  logic clr,
  output logic mid,
  output logic last
);
  localparam int TW = $clog2(DIV);
  logic [TW-1:0] tick;
  always_ff @(posedge CLK or negedge RSTn)
    if (!RSTn) tick <= '0;
    else tick <= (clr || last) ? '0 : tick + 1'b1;
  assign mid = tick == TW'(DIV / 2 - 1);
  assign last = tick == TW'(DIV - 1);
endmodule

// File: rtl/serial_frame_ctrl.sv
// serial_frame_ctrl: receives an idle-high serial frame and drives an external shift register
// one bit per pulse, then holds the word behind a valid/ack handshake.
module serial_frame_ctrl
  import serial_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DIV = DIV_DEF
) (
  input  logic CLK,
  input  logic RSTn,
  input  logic SER_IN,
  input  logic ACK,
  output logic SHIFT_EN,
  output logic SHIFT_DATA,
  output logic FRAME_VALID,
  output logic FRAME_ERR,
  output logic BUSY
);
  localparam int BW = $clog2(WIDTH + 1);
  frame_state_t state;
  logic [BW-1:0] bitcnt;
  logic s1, s, clr, mid, last;
  // the timer restarts at the start edge and again at mid-start, so data samples land mid-bit
  assign clr = state == IDLE || (state == START && mid);
  bit_timer #(.DIV(DIV)) u_timer (.CLK(CLK), .RSTn(RSTn), .clr(clr), .mid(mid), .last(last));
  always_ff @(posedge CLK or negedge RSTn)
    if (!RSTn) begin
      s1 <= 1'b1;
      s <= 1'b1;
      state <= IDLE;
      bitcnt <= '0;
      SHIFT_EN <= 1'b0;
      SHIFT_DATA <= 1'b0;
      FRAME_VALID <= 1'b0;
      FRAME_ERR <= 1'b0;
      BUSY <= 1'b0;
    end else begin
      s1 <= SER_IN;
      s <= s1;
      SHIFT_EN <= 1'b0;
      SHIFT_DATA <= 1'b0;
      FRAME_ERR <= 1'b0;
      case (state)
        IDLE: if (!s) begin
          state <= START;
          BUSY <= 1'b1;
        end
        START: if (mid) begin
          state <= s ? IDLE : DATA;
          BUSY <= !s;
          bitcnt <= '0;
        end
        DATA: if (last) begin
          SHIFT_EN <= 1'b1;
          SHIFT_DATA <= s;
          bitcnt <= bitcnt + 1'b1;
          if (bitcnt == BW'(WIDTH - 1)) state <= STOP;
        end
        STOP: if (last) begin
          state <= s ? HOLD : WAIT_IDLE;
          FRAME_VALID <= s;
          FRAME_ERR <= !s;
        end
        HOLD: if (ACK) begin
          state <= IDLE;
          FRAME_VALID <= 1'b0;
          BUSY <= 1'b0;
        end
        WAIT_IDLE: if (s) begin
          state <= IDLE;
          BUSY <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_serial_frame_ctrl.sv
// tb_serial_frame_ctrl: directed scenarios for serial_frame_ctrl with WIDTH=10, DIV=4.
module tb_serial_frame_ctrl;
  localparam int W = 10;
  localparam int D = 4;
  logic CLK = 0, RSTn = 0, SER_IN = 1, ACK = 0;
  logic SHIFT_EN, SHIFT_DATA, FRAME_VALID, FRAME_ERR, BUSY;
  int total = 0, bad = 0;
  int cyc = 0, npulse = 0, fv_rise = -1, err_edge = -1, err_cnt = 0, busy_cnt = 0;
  int pe [64];
  logic [63:0] pbits = '0;
  logic fv_q = 0;
  logic [W-1:0] sreg;

  serial_frame_ctrl #(.WIDTH(W), .DIV(D)) dut (
    .CLK(CLK), .RSTn(RSTn), .SER_IN(SER_IN), .ACK(ACK), .SHIFT_EN(SHIFT_EN),
    .SHIFT_DATA(SHIFT_DATA), .FRAME_VALID(FRAME_VALID), .FRAME_ERR(FRAME_ERR), .BUSY(BUSY));

  always #5 CLK = ~CLK;

  // external shift register the sequencer drives
  always @(posedge CLK or negedge RSTn)
    if (!RSTn) sreg <= '0;
    else if (SHIFT_EN) sreg <= {sreg[W-2:0], SHIFT_DATA};

  // edge numbers: the edge that sees a value is recorded as cyc+1
  always @(posedge CLK) begin
    cyc <= cyc + 1;
    if (SHIFT_EN) begin
      pe[npulse % 64] <= cyc + 1;
      pbits <= {pbits[62:0], SHIFT_DATA};
      npulse <= npulse + 1;
    end
    if (FRAME_VALID && !fv_q) fv_rise <= cyc + 1;
    fv_q <= FRAME_VALID;
    if (FRAME_ERR) begin
      err_edge <= cyc + 1;
      err_cnt <= err_cnt + 1;
    end
    if (BUSY) busy_cnt <= busy_cnt + 1;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic b, input int n);
    SER_IN = b;
    tick(n);
  endtask

  // call #1 after an edge; t0 is the next edge; returns #1 after edge t0+47 with the line idle
  task automatic send(input logic [W-1:0] d, input logic sb);
    drive(1'b0, D);
    for (int k = W - 1; k >= 0; k--) drive(d[k], D);
    drive(sb, D);
    SER_IN = 1'b1;
  endtask

  task automatic test_reset;
    RSTn = 0;
    tick(3);
    total++; if (SHIFT_EN !== 1'b0) begin bad++; $display("FAIL rst_shift_en got=%b exp=0", SHIFT_EN); end
    total++; if (SHIFT_DATA !== 1'b0) begin bad++; $display("FAIL rst_shift_data got=%b exp=0", SHIFT_DATA); end
    total++; if (FRAME_VALID !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", FRAME_VALID); end
    total++; if (FRAME_ERR !== 1'b0) begin bad++; $display("FAIL rst_err got=%b exp=0", FRAME_ERR); end
    total++; if (BUSY !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", BUSY); end
    RSTn = 1;
    tick(2);
    ACK = 1;
    tick(2);
    ACK = 0;
    tick(1);
    total++; if ({FRAME_VALID, BUSY} !== 2'b00) begin bad++; $display("FAIL idle_ack got=%b exp=00", {FRAME_VALID, BUSY}); end
  endtask

  task automatic test_good_frame;
    int t0, n0;
    logic [W-1:0] d;
    d = 10'b1011001110;
    t0 = cyc + 1;
    n0 = npulse;
    send(d, 1'b1);
    tick(2);
    total++; if (npulse - n0 !== 10) begin bad++; $display("FAIL good_pulses got=%0d exp=10", npulse - n0); end
    total++; if (pe[n0 % 64] !== t0 + 9) begin bad++; $display("FAIL good_first_pulse got=%0d exp=%0d", pe[n0 % 64], t0 + 9); end
    total++; if (pe[(n0 + 9) % 64] !== t0 + 45) begin bad++; $display("FAIL good_last_pulse got=%0d exp=%0d", pe[(n0 + 9) % 64], t0 + 45); end
    total++; if (pbits[W-1:0] !== d) begin bad++; $display("FAIL good_bits got=%b exp=%b", pbits[W-1:0], d); end
    total++; if (sreg !== d) begin bad++; $display("FAIL good_sreg got=%b exp=%b", sreg, d); end
    total++; if (fv_rise !== t0 + 49) begin bad++; $display("FAIL good_valid_edge got=%0d exp=%0d", fv_rise, t0 + 49); end
    tick(5);
    total++; if ({FRAME_VALID, BUSY} !== 2'b11) begin bad++; $display("FAIL good_hold got=%b exp=11", {FRAME_VALID, BUSY}); end
    ACK = 1;
    tick(1);
    ACK = 0;
    total++; if ({FRAME_VALID, BUSY} !== 2'b00) begin bad++; $display("FAIL good_ack got=%b exp=00", {FRAME_VALID, BUSY}); end
  endtask

  task automatic test_glitch;
    int n0, b0;
    n0 = npulse;
    b0 = busy_cnt;
    drive(1'b0, 1);
    drive(1'b1, 10);
    total++; if (busy_cnt - b0 < 1 || busy_cnt - b0 > 4) begin bad++; $display("FAIL glitch_busy_cycles got=%0d exp=1..4", busy_cnt - b0); end
    total++; if (npulse !== n0) begin bad++; $display("FAIL glitch_pulses got=%0d exp=0", npulse - n0); end
    total++; if (BUSY !== 1'b0) begin bad++; $display("FAIL glitch_idle got=%b exp=0", BUSY); end
  endtask

  task automatic test_bad_stop;
    int t0, n0, e0;
    t0 = cyc + 1;
    n0 = npulse;
    e0 = err_cnt;
    send(10'b1011001110, 1'b0);
    SER_IN = 1'b0;
    tick(2);
    total++; if (npulse - n0 !== 10) begin bad++; $display("FAIL bad_pulses got=%0d exp=10", npulse - n0); end
    total++; if (err_edge !== t0 + 49) begin bad++; $display("FAIL bad_err_edge got=%0d exp=%0d", err_edge, t0 + 49); end
    total++; if ({FRAME_VALID, FRAME_ERR} !== 2'b00) begin bad++; $display("FAIL bad_flags got=%b exp=00", {FRAME_VALID, FRAME_ERR}); end
    tick(20);
    total++; if (BUSY !== 1'b1 || npulse - n0 !== 10) begin bad++; $display("FAIL bad_break busy=%b pulses=%0d exp busy=1 pulses=10", BUSY, npulse - n0); end
    SER_IN = 1'b1;
    tick(6);
    total++; if (BUSY !== 1'b0 || err_cnt - e0 !== 1) begin bad++; $display("FAIL bad_recover busy=%b errs=%0d exp busy=0 errs=1", BUSY, err_cnt - e0); end
  endtask

  task automatic test_hold_drop;
    int n0;
    send(10'b1100110011, 1'b1);
    tick(4);
    n0 = npulse;
    send(10'b0101010101, 1'b1);
    tick(6);
    total++; if (npulse !== n0) begin bad++; $display("FAIL hold_pulses got=%0d exp=0", npulse - n0); end
    total++; if (FRAME_VALID !== 1'b1) begin bad++; $display("FAIL hold_valid got=%b exp=1", FRAME_VALID); end
    total++; if (sreg !== 10'b1100110011) begin bad++; $display("FAIL hold_sreg got=%b exp=1100110011", sreg); end
    ACK = 1;
    tick(1);
    ACK = 0;
    total++; if ({FRAME_VALID, BUSY} !== 2'b00) begin bad++; $display("FAIL hold_ack got=%b exp=00", {FRAME_VALID, BUSY}); end
    tick(3);
  endtask

  task automatic test_reset_mid;
    int t0, n0;
    fork
      send(10'b1111100000, 1'b1);
      begin
        tick(25);
        RSTn = 0;
        #1;
        total++; if ({SHIFT_EN, SHIFT_DATA, FRAME_VALID, FRAME_ERR, BUSY} !== 5'b0) begin bad++; $display("FAIL mid_rst_outputs got=%b exp=00000", {SHIFT_EN, SHIFT_DATA, FRAME_VALID, FRAME_ERR, BUSY}); end
        total++; if (sreg !== '0) begin bad++; $display("FAIL mid_rst_sreg got=%b exp=0", sreg); end
      end
    join
    RSTn = 1;
    tick(3);
    t0 = cyc + 1;
    n0 = npulse;
    send(10'b0110100101, 1'b1);
    tick(2);
    total++; if (npulse - n0 !== 10) begin bad++; $display("FAIL mid_pulses got=%0d exp=10", npulse - n0); end
    total++; if (pe[n0 % 64] !== t0 + 9) begin bad++; $display("FAIL mid_first_pulse got=%0d exp=%0d", pe[n0 % 64], t0 + 9); end
    total++; if (fv_rise !== t0 + 49) begin bad++; $display("FAIL mid_valid_edge got=%0d exp=%0d", fv_rise, t0 + 49); end
    total++; if (sreg !== 10'b0110100101) begin bad++; $display("FAIL mid_sreg got=%b exp=0110100101", sreg); end
    ACK = 1;
    tick(1);
    ACK = 0;
    tick(3);
  endtask

  task automatic test_back_to_back;
    int t0, n0;
    t0 = cyc + 1;
    n0 = npulse;
    fork
      begin
        send(10'b1000000001, 1'b1);
        send(10'b0011110110, 1'b1);
      end
      begin
        tick(49);
        ACK = 1;
        tick(1);
        ACK = 0;
      end
    join
    tick(2);
    total++; if (npulse - n0 !== 20) begin bad++; $display("FAIL b2b_pulses got=%0d exp=20", npulse - n0); end
    total++; if (pbits[19:0] !== 20'b1000000001_0011110110) begin bad++; $display("FAIL b2b_bits got=%b exp=10000000010011110110", pbits[19:0]); end
    total++; if (fv_rise !== t0 + 48 + 49) begin bad++; $display("FAIL b2b_valid_edge got=%0d exp=%0d", fv_rise, t0 + 97); end
    total++; if (sreg !== 10'b0011110110 || FRAME_VALID !== 1'b1) begin bad++; $display("FAIL b2b_word sreg=%b valid=%b exp 0011110110/1", sreg, FRAME_VALID); end
    ACK = 1;
    tick(1);
    ACK = 0;
  endtask

  initial begin
    test_reset;
    test_good_frame;
    tick(3);
    test_glitch;
    test_bad_stop;
    test_hold_drop;
    test_reset_mid;
    test_back_to_back;
    tick(4);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
